// File: rtl/pll_seq_pkg.sv
// Shared types for the iCE40 PLL lock sequencer.
// State encoding and relock counter width.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam int STATE_W  = 3;
  localparam int RELOCK_W = 8;

endpackage

// File: rtl/pll_lock_seq_sync_2ff.sv
// 1-bit two-flop synchroniser, async active-low reset.
// Ports: clk, rst_n, d_i (async in), q_o (synchronised out).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_seq.sv
// Power-up/relock sequencer for the iCE40 PLL: drives
// RESETB/BYPASS, watches LOCK, issues the system reset.
// Ports: clk, rst_n, pll_lock_i, bypass_req_i, restart_i,
//   pll_resetb_o, pll_bypass_o, sys_rst_n_o, locked_o,
//   fault_o, state_o[2:0], relock_cnt_o[7:0].
// Option: PLL_RELOCK_EN enables bounded relock retries.
module pll_lock_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pll_lock_i,
  input  logic                bypass_req_i,
  input  logic                restart_i,
  output logic                pll_resetb_o,
  output logic                pll_bypass_o,
  output logic                sys_rst_n_o,
  output logic                locked_o,
  output logic                fault_o,
  output logic [STATE_W-1:0]  state_o,
  output logic [RELOCK_W-1:0] relock_cnt_o
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 ||
      STABLE_CYCLES < 1 || MAX_RETRIES < 0 ||
      MAX_RETRIES >= (1 << RELOCK_W)) begin : g_cfg_err
    $error("pll_lock_seq: illegal parameters");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resetb_q, resetb_d;
  logic             bypass_q, bypass_d;
  logic             srst_q, srst_d;
  logic             locked_q, locked_d;
  logic             fault_q, fault_d;
  logic             lock_s;
  logic             lk;
  logic             fail;

`ifdef PLL_RELOCK_EN
  logic [RELOCK_W-1:0] relock_q, relock_d;
`endif

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock_i),
    .q_o   (lock_s)
  );

  // In bypass the PLL output is the reference, so LOCK is moot.
  assign lk = lock_s | bypass_q;

  always_comb begin
    state_d = state_q;
    fail    = 1'b0;
`ifdef PLL_RELOCK_EN
    relock_d = relock_q;
`endif

    unique case (state_q)
      S_HOLD: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lk) state_d = S_STABLE;
        else if (cnt_q == TMO_LAST) fail = 1'b1;
      end
      S_STABLE: begin
        if (!lk) state_d = S_WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lk) fail = 1'b1;
        else if (bypass_req_i != bypass_q) state_d = S_HOLD;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_HOLD;
    endcase

`ifdef PLL_RELOCK_EN
    // Count stops at MAX_RETRIES (FAULT), so it cannot wrap.
    if (fail) begin
      if (relock_q == RELOCK_W'(MAX_RETRIES)) begin
        state_d = S_FAULT;
      end else begin
        state_d  = S_HOLD;
        relock_d = relock_q + 8'd1;
      end
    end
`else
    if (fail) state_d = S_FAULT;
`endif

    if (restart_i) begin
      state_d = S_HOLD;
`ifdef PLL_RELOCK_EN
      relock_d = '0;
`endif
    end

    if (state_d != state_q || restart_i) cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else cnt_d = cnt_q + CNT_W'(1);

    // Bypass is only latched when (re)entering HOLD.
    bypass_d = bypass_q;
    if (state_d == S_HOLD &&
        (state_q != S_HOLD || restart_i))
      bypass_d = bypass_req_i;

    resetb_d = (state_d == S_WAIT_LOCK) ||
               (state_d == S_STABLE) ||
               (state_d == S_RUN);
    srst_d   = (state_d == S_RUN);
    locked_d = (state_d == S_RUN);
    fault_d  = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      resetb_q <= 1'b0;
      bypass_q <= 1'b0;
      srst_q   <= 1'b0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      resetb_q <= resetb_d;
      bypass_q <= bypass_d;
      srst_q   <= srst_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
    end
  end

`ifdef PLL_RELOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) relock_q <= '0;
    else        relock_q <= relock_d;
  end

  assign relock_cnt_o = relock_q;
`else
  assign relock_cnt_o = '0;
`endif

  assign pll_resetb_o = resetb_q;
  assign pll_bypass_o = bypass_q;
  assign sys_rst_n_o  = srst_q;
  assign locked_o     = locked_q;
  assign fault_o      = fault_q;
  assign state_o      = state_q;

endmodule
